// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder built around a 4-bit step: one nibble per clock, LSB first,
// with valid/ready handshakes on both the operand and the result side.
module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_work;
    logic               r_carry;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_out_valid;

    logic [IDX_W+1:0]   w_shamt;
    logic [3:0]         w_nib_a;
    logic [3:0]         w_nib_b;
    logic [4:0]         w_step;
    logic [WIDTH-1:0]   w_work_next;
    logic               w_last;

    // Select the current nibble pair and merge this step's sum nibble into the work word
    assign w_shamt     = {r_idx, 2'b00};
    assign w_nib_a     = 4'(r_opa >> w_shamt);
    assign w_nib_b     = 4'(r_opb >> w_shamt);
    assign w_step      = 5'(w_nib_a) + 5'(w_nib_b) + 5'(r_carry);
    assign w_work_next = (r_work & ~(WIDTH'(4'hF) << w_shamt))
                       | (WIDTH'(w_step[3:0]) << w_shamt);
    assign w_last      = (r_idx == IDX_W'(NIB - 1));

    assign in_ready  = (r_state == S_IDLE) & ~rst;
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_work      <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_opa   <= a;
                        r_opb   <= b;
                        r_carry <= cin;
                        r_work  <= '0;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_work  <= w_work_next;
                    r_carry <= w_step[4];
                    r_idx   <= r_idx + IDX_W'(1);
                    // Only the completed word is ever published on sum
                    if (w_last) begin
                        r_sum       <= w_work_next;
                        r_cout      <= w_step[4];
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: a 16-bit and a 4-bit instance share clock and reset.
module tb_nibble_serial_adder;

    localparam int unsigned W16 = 16;
    localparam int unsigned W4  = 4;
    localparam int unsigned TMO = 60;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            iv16, ir16, ov16, or16, cin16, cout16, busy16;
    logic [W16-1:0]  a16, b16, sum16;
    logic            iv4, ir4, ov4, or4, cin4, cout4, busy4;
    logic [W4-1:0]   a4, b4, sum4;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_res16 = 0;
    int n_res4  = 0;

    nibble_serial_adder #(.WIDTH(W16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(cin16),
        .out_valid(ov16), .out_ready(or16), .sum(sum16), .cout(cout16), .busy(busy16)
    );

    nibble_serial_adder #(.WIDTH(W4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(cin4),
        .out_valid(ov4), .out_ready(or4), .sum(sum4), .cout(cout4), .busy(busy4)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // 16-bit scoreboard: push on accepted operands, pop on result handshake
    logic [W16:0] q16[$];
    int           cap16 = 0;
    logic         ov16_d = 1'b0;
    always @(negedge clk) begin
        logic [W16:0] e;
        if (rst) begin
            q16.delete();
        end else begin
            if (ov16 && !ov16_d) check("lat16", 32'(cyc - cap16), 32'(W16 / 4 + 1));
            if (ov16 && or16) begin
                if (q16.size() == 0) begin
                    check("sb16_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q16.pop_front();
                    check("sum16", 32'(sum16), 32'(e[W16-1:0]));
                    check("cout16", 32'(cout16), 32'(e[W16]));
                    n_res16++;
                end
            end
            if (iv16 && ir16) begin
                q16.push_back((W16+1)'(a16) + (W16+1)'(b16) + (W16+1)'(cin16));
                cap16 = cyc;
            end
        end
        ov16_d = ov16;
    end

    // 4-bit scoreboard
    logic [W4:0] q4[$];
    int          cap4 = 0;
    logic        ov4_d = 1'b0;
    always @(negedge clk) begin
        logic [W4:0] e;
        if (rst) begin
            q4.delete();
        end else begin
            if (ov4 && !ov4_d) check("lat4", 32'(cyc - cap4), 32'(W4 / 4 + 1));
            if (ov4 && or4) begin
                if (q4.size() == 0) begin
                    check("sb4_unexpected", 32'd1, 32'd0);
                end else begin
                    e = q4.pop_front();
                    check("sum4", 32'(sum4), 32'(e[W4-1:0]));
                    check("cout4", 32'(cout4), 32'(e[W4]));
                    n_res4++;
                end
            end
            if (iv4 && ir4) begin
                q4.push_back((W4+1)'(a4) + (W4+1)'(b4) + (W4+1)'(cin4));
                cap4 = cyc;
            end
        end
        ov4_d = ov4;
    end

    task automatic send16(input logic [W16-1:0] a, input logic [W16-1:0] b, input logic c);
        bit ok = 1'b0;
        @(posedge clk); #1;
        a16 = a; b16 = b; cin16 = c; iv16 = 1'b1;
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            if (ir16) begin ok = 1'b1; break; end
        end
        if (!ok) check("send16_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        iv16 = 1'b0;
    endtask

    task automatic send4(input logic [W4-1:0] a, input logic [W4-1:0] b, input logic c);
        bit ok = 1'b0;
        @(posedge clk); #1;
        a4 = a; b4 = b; cin4 = c; iv4 = 1'b1;
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            if (ir4) begin ok = 1'b1; break; end
        end
        if (!ok) check("send4_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        iv4 = 1'b0;
    endtask

    task automatic wait_idle;
        bit ok = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            if (!busy16 && !busy4) begin ok = 1'b1; break; end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_ov16;
        bit ok = 1'b0;
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            if (ov16) begin ok = 1'b1; break; end
        end
        if (!ok) check("ov16_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        iv16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0;
        iv4  = 1'b0; or4  = 1'b1; a4  = '0; b4  = '0; cin4  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(ov16), 32'd0);
        check("rst_sum", 32'(sum16), 32'd0);
        check("rst_cout", 32'(cout16), 32'd0);
        check("rst_in_ready", 32'(ir16), 32'd0);
        check("rst_busy", 32'(busy16), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(ir16), 32'd1);

        send16(16'h1234, 16'h4321, 1'b0);
        send16(16'hFFFF, 16'h0001, 1'b0);
        send16(16'hFFFF, 16'hFFFF, 1'b1);
        wait_idle();

        // Backpressure: result must hold while the consumer stalls
        or16 = 1'b0;
        send16(16'h8001, 16'h8002, 1'b1);
        wait_ov16();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(ov16), 32'd1);
            check("bp_sum", 32'(sum16), 32'h0004);
            check("bp_cout", 32'(cout16), 32'd1);
            check("bp_in_ready", 32'(ir16), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        or16 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_valid", 32'(ov16), 32'd0);
        check("bp_release_ready", 32'(ir16), 32'd1);

        // New pair offered during RUN is held off until in_ready returns
        send16(16'h1111, 16'h2222, 1'b0);
        a16 = 16'h0F0F; b16 = 16'h0101; cin16 = 1'b0; iv16 = 1'b1;
        @(negedge clk);
        check("run_in_ready", 32'(ir16), 32'd0);
        send16(16'h0F0F, 16'h0101, 1'b0);
        wait_idle();

        // Reset after two nibble steps aborts the operation
        send16(16'hAAAA, 16'h5555, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_valid", 32'(ov16), 32'd0);
        check("abort_sum", 32'(sum16), 32'd0);
        check("abort_cout", 32'(cout16), 32'd0);
        check("abort_busy", 32'(busy16), 32'd0);
        check("abort_in_ready", 32'(ir16), 32'd1);
        repeat (6) @(negedge clk);
        check("abort_no_result", 32'(ov16), 32'd0);
        send16(16'h0001, 16'h0001, 1'b0);
        wait_idle();
        check("after_abort_sum", 32'(sum16), 32'h0002);

        send4(4'd7, 4'd9, 1'b1);
        wait_idle();
        check("w4_sum", 32'(sum4), 32'h1);
        check("w4_cout", 32'(cout4), 32'd1);

        for (int i = 0; i < 20; i++) begin
            send16(16'($urandom), 16'($urandom), 1'($urandom));
            send4(4'($urandom), 4'($urandom), 1'($urandom));
        end
        wait_idle();
        repeat (2) @(negedge clk);

        check("res16_count", 32'(n_res16), 32'd27);
        check("res4_count", 32'(n_res4), 32'd21);
        check("q16_empty", 32'(q16.size()), 32'd0);
        check("q4_empty", 32'(q4.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
